// File: rtl/controle_escrita_registrador.sv
// Register-file write-port arbiter: grants writeback or external loader.
// Ports: clock/reset, wb_* and ent_* requests; we/waddr/wdata, sel_clock, ent_pronto, stall.
module controle_escrita_registrador #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int MAX_ESPERA = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wb_valido,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_dado,
  input  logic              ent_valido,
  input  logic [ADDR_W-1:0] ent_reg,
  input  logic [DATA_W-1:0] ent_dado,
  output logic              ent_pronto,
  output logic              stall,
  output logic [1:0]        sel_clock,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata
);

  localparam logic [1:0] OCIOSO      = 2'b00;
  localparam logic [1:0] ESCRITA_WB  = 2'b01;
  localparam logic [1:0] ESCRITA_ENT = 2'b10;
  localparam logic [3:0] LP_MAX      = 4'(MAX_ESPERA);

  logic [1:0]        r_estado;
  logic [3:0]        r_espera;
  logic              r_we;
  logic              r_pronto;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  logic w_ent_eff;
  logic w_forca;
  logic w_grant_ent;
  logic w_grant_wb;

  // External request is masked for one cycle after its grant so the
  // requester has a guard cycle to drop ent_valido.
  assign w_ent_eff   = ent_valido && (r_estado != ESCRITA_ENT);
  assign w_forca     = (r_espera == LP_MAX);
  assign w_grant_ent = w_ent_eff && (!wb_valido || w_forca);
  assign w_grant_wb  = wb_valido && !w_grant_ent;

  assign stall = wb_valido && w_ent_eff && w_forca;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado <= OCIOSO;
      r_espera <= 4'd0;
      r_we     <= 1'b0;
      r_pronto <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else begin
      unique case (1'b1)
        w_grant_ent: begin
          r_estado <= ESCRITA_ENT;
          r_we     <= 1'b1;
          r_pronto <= 1'b1;
          r_waddr  <= ent_reg;
          r_wdata  <= ent_dado;
        end
        w_grant_wb: begin
          r_estado <= ESCRITA_WB;
          r_we     <= 1'b1;
          r_pronto <= 1'b0;
          r_waddr  <= wb_rd;
          r_wdata  <= wb_dado;
        end
        default: begin
          r_estado <= OCIOSO;
          r_we     <= 1'b0;
          r_pronto <= 1'b0;
        end
      endcase

      // Starvation counter: counts external cycles lost to writeback.
      if (w_grant_ent || !ent_valido) begin
        r_espera <= 4'd0;
      end else if (w_ent_eff && w_grant_wb && r_espera != 4'hF) begin
        r_espera <= r_espera + 4'd1;
      end
    end
  end

  assign sel_clock  = r_estado;
  assign we         = r_we;
  assign ent_pronto = r_pronto;
  assign waddr      = r_waddr;
  assign wdata      = r_wdata;

endmodule

// File: tb/tb_controle_escrita_registrador.sv
// Bench for controle_escrita_registrador: directed scenarios plus a
// randomized run checked against a grant-level reference model.
module tb_controle_escrita_registrador;

  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int MAX = 4;
  localparam int OW  = 1 + 2 + 1 + AW + DW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          wb_valido = 1'b0;
  logic [AW-1:0] wb_rd = '0;
  logic [DW-1:0] wb_dado = '0;
  logic          ent_valido = 1'b0;
  logic [AW-1:0] ent_reg = '0;
  logic [DW-1:0] ent_dado = '0;
  logic          ent_pronto;
  logic          stall;
  logic [1:0]    sel_clock;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  controle_escrita_registrador #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_ESPERA(MAX)
  ) dut (
    .clock(clock), .reset(reset),
    .wb_valido(wb_valido), .wb_rd(wb_rd), .wb_dado(wb_dado),
    .ent_valido(ent_valido), .ent_reg(ent_reg), .ent_dado(ent_dado),
    .ent_pronto(ent_pronto), .stall(stall), .sel_clock(sel_clock),
    .we(we), .waddr(waddr), .wdata(wdata)
  );

  always #5 clock = ~clock;

  logic [OW-1:0] obs;
  assign obs = {we, sel_clock, ent_pronto, waddr, wdata};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: tracks how many consecutive external cycles were
  // lost to writeback and whether the last grant was external.
  bit            m_prev_ent = 0;
  int            m_lost     = 0;
  logic [OW-1:0] m_exp      = '0;
  bit            m_stall    = 0;
  logic          stall_obs;

  task automatic model_reset();
    m_prev_ent = 0;
    m_lost     = 0;
    m_exp      = '0;
    m_stall    = 0;
  endtask

  task automatic model_edge();
    bit eff;
    bit forced;
    eff     = ent_valido && !m_prev_ent;
    forced  = (m_lost == MAX);
    m_stall = wb_valido && eff && forced;
    if (eff && (!wb_valido || forced)) begin
      m_exp      = {1'b1, 2'd2, 1'b1, ent_reg, ent_dado};
      m_lost     = 0;
      m_prev_ent = 1;
    end else begin
      m_prev_ent = 0;
      if (wb_valido)
        m_exp = {1'b1, 2'd1, 1'b0, wb_rd, wb_dado};
      else
        m_exp = {1'b0, 2'd0, 1'b0, m_exp[AW+DW-1:0]};
      if (!ent_valido) m_lost = 0;
      else if (wb_valido && eff) m_lost = (m_lost < 15) ? m_lost + 1 : 15;
    end
  endtask

  // Inputs are set just after an edge; stall is sampled mid-cycle,
  // outputs are sampled 1 time unit after the next rising edge.
  task automatic cycle();
    #1;
    stall_obs = stall;
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valido  = 0;
    ent_valido = 0;
  endtask

  task automatic test_reset();
    logic [OW-1:0] e;
    #2;
    n_tests++;
    if (obs !== '0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init: got %h stall=%b want 0", obs, stall);
    end
    @(negedge clock);
    reset = 0;
    model_reset();
    @(posedge clock);
    #1;
    wb_valido = 1; wb_rd = 5'd9; wb_dado = 32'hCAFE0001;
    cycle();
    e = {1'b1, 2'd1, 1'b0, 5'd9, 32'hCAFE0001};
    n_tests++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset_pre_write: got %h want %h", obs, e);
    end
    #2;
    reset = 1;
    #1;
    n_tests++;
    if (obs !== '0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got %h stall=%b want 0", obs, stall);
    end
    idle_inputs();
    #1;
    reset = 0;
    model_reset();
    @(posedge clock);
    #1;
    n_tests++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_after: got %h want 0", obs);
    end
  endtask

  task automatic test_wb_only();
    logic [OW-1:0] e;
    wb_valido = 1; wb_rd = 5'd5; wb_dado = 32'hDEADBEEF;
    cycle();
    e = {1'b1, 2'd1, 1'b0, 5'd5, 32'hDEADBEEF};
    n_tests++;
    if (obs !== e || stall_obs !== 1'b0) begin
      n_fail++;
      $display("FAIL wb_only: got %h st=%b want %h", obs, stall_obs, e);
    end
    wb_valido = 0;
    cycle();
    e = {1'b0, 2'd0, 1'b0, 5'd5, 32'hDEADBEEF};
    n_tests++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL wb_only_idle: got %h want %h", obs, e);
    end
  endtask

  task automatic test_ent_only();
    logic [OW-1:0] g;
    logic [OW-1:0] q;
    ent_valido = 1; ent_reg = 5'd3; ent_dado = 32'h12;
    g = {1'b1, 2'd2, 1'b1, 5'd3, 32'h12};
    q = {1'b0, 2'd0, 1'b0, 5'd3, 32'h12};
    cycle();
    n_tests++;
    if (obs !== g) begin
      n_fail++;
      $display("FAIL ent_grant: got %h want %h", obs, g);
    end
    cycle();
    n_tests++;
    if (obs !== q) begin
      n_fail++;
      $display("FAIL ent_guard: got %h want %h", obs, q);
    end
    cycle();
    n_tests++;
    if (obs !== g) begin
      n_fail++;
      $display("FAIL ent_regrant: got %h want %h", obs, g);
    end
    ent_valido = 0;
    cycle();
  endtask

  task automatic test_contention();
    logic [OW-1:0] e;
    ent_valido = 1; ent_reg = 5'd7; ent_dado = 32'hE0E0E0E0;
    wb_valido  = 1;
    for (int i = 0; i < MAX; i++) begin
      wb_rd = 5'(i + 1); wb_dado = 32'(100 + i);
      cycle();
      e = {1'b1, 2'd1, 1'b0, 5'(i + 1), 32'(100 + i)};
      n_tests++;
      if (obs !== e || stall_obs !== 1'b0) begin
        n_fail++;
        $display("FAIL cont_wb%0d: got %h st=%b want %h st=0",
                 i, obs, stall_obs, e);
      end
    end
    wb_rd = 5'd9; wb_dado = 32'd200;
    cycle();
    e = {1'b1, 2'd2, 1'b1, 5'd7, 32'hE0E0E0E0};
    n_tests++;
    if (obs !== e || stall_obs !== 1'b1) begin
      n_fail++;
      $display("FAIL cont_forced: got %h st=%b want %h st=1",
               obs, stall_obs, e);
    end
    ent_valido = 0;
    cycle();
    e = {1'b1, 2'd1, 1'b0, 5'd9, 32'd200};
    n_tests++;
    if (obs !== e || stall_obs !== 1'b0) begin
      n_fail++;
      $display("FAIL cont_resume: got %h st=%b want %h", obs, stall_obs, e);
    end
    wb_valido = 0;
    cycle();
  endtask

  task automatic test_guard_wb();
    logic [OW-1:0] e;
    ent_valido = 1; ent_reg = 5'd3; ent_dado = 32'h12;
    cycle();
    wb_valido = 1; wb_rd = 5'd4; wb_dado = 32'h44;
    cycle();
    e = {1'b1, 2'd1, 1'b0, 5'd4, 32'h44};
    n_tests++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL guard_wb: got %h want %h", obs, e);
    end
    wb_valido = 0;
    cycle();
    e = {1'b1, 2'd2, 1'b1, 5'd3, 32'h12};
    n_tests++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL guard_regrant: got %h want %h", obs, e);
    end
    ent_valido = 0;
    cycle();
  endtask

  task automatic test_espera_clear();
    int lost;
    ent_valido = 1; ent_reg = 5'd11; ent_dado = 32'h5A5A;
    wb_valido = 1; wb_rd = 5'd2; wb_dado = 32'h22;
    cycle();
    cycle();
    ent_valido = 0;
    cycle();
    ent_valido = 1;
    lost = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (sel_clock == 2'd2) break;
      lost++;
    end
    n_tests++;
    if (lost != MAX || stall_obs !== 1'b1 || ent_pronto !== 1'b1) begin
      n_fail++;
      $display("FAIL espera_clear: lost=%0d st=%b pr=%b want lost=%0d st=1 pr=1",
               lost, stall_obs, ent_pronto, MAX);
    end
    idle_inputs();
    cycle();
    cycle();
  endtask

  task automatic test_random();
    int errs = 0;
    bit ent_pend = 0;
    for (int c = 0; c < 400; c++) begin
      if (!m_stall || !wb_valido) begin
        wb_valido = ($urandom_range(0, 99) < 60);
        wb_rd     = 5'($urandom);
        wb_dado   = $urandom;
      end
      if (!ent_pend) begin
        ent_valido = ($urandom_range(0, 99) < 50);
        ent_reg    = 5'($urandom);
        ent_dado   = $urandom;
        ent_pend   = ent_valido;
      end
      cycle();
      n_tests++;
      if (obs !== m_exp || stall_obs !== m_stall) begin
        n_fail++;
        errs++;
        if (errs < 10)
          $display("FAIL rand_c%0d: got %h st=%b want %h st=%b",
                   c, obs, stall_obs, m_exp, m_stall);
      end
      if (m_exp[OW-4]) ent_pend = 0;
    end
    idle_inputs();
    cycle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_wb_only();
    test_ent_only();
    test_contention();
    test_guard_wb();
    test_espera_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
